// File: rtl/nibble_fifo_pkg.sv
// Shared types and constants for the nibble FIFO front-end controller.
package nibble_fifo_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int WORD_W     = 32;
    localparam int FIFO_DEPTH = 32;

    // Controller phases: accept writes, hold the FIFO flush, latch the flushed word.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // (a + b) mod n for operands already in range 0..n-1.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter. The search starts at the internal pointer and
// wraps. After a grant the pointer moves to the slot just past the grantee, so a
// requester that stays valid is served at least once every N grants.
module rr_arbiter
    import nibble_fifo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant,
    output logic         found
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] next_ptr;

    // Find the first valid requester at or after rr_ptr, with wrap-around.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        grant     = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (enable && !found && valid[PW'(wrap_add(int'(rr_ptr), i, N))]) begin
                found     = 1'b1;
                grant_idx = PW'(wrap_add(int'(rr_ptr), i, N));
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign next_ptr = PW'(wrap_add(int'(grant_idx), 1, N));

    // The pointer advances past the grantee only when a grant actually happens.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/nibble_fifo_sched.sv
// Front-end controller for the 32-entry nibble FIFO. Arbitrates nibble producers
// onto the FIFO write port, sequences flushes (explicit or after WORD_NIBBLES
// accepted nibbles) and presents each flushed word with a one-cycle valid pulse.
module nibble_fifo_sched
    import nibble_fifo_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WORD_NIBBLES = 8,
    parameter int FLUSH_HOLD   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NIBBLE_W*NUM_REQ-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic                         flush_req_i,
    input  logic                         fifo_full_i,
    output logic                         fifo_wr_valid_o,
    output logic [NIBBLE_W-1:0]          fifo_wr_data_o,
    output logic                         fifo_flush_o,
    input  logic [WORD_W-1:0]            fifo_rd_data_i,
    output logic [WORD_W-1:0]            word_o,
    output logic                         word_valid_o,
    output logic                         busy_o
);

    localparam int CNT_W  = $clog2(WORD_NIBBLES + 1);
    localparam int HOLD_W = $clog2(FLUSH_HOLD);

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [CNT_W-1:0]  nib_cnt, nib_nxt;
    logic              pend, pend_nxt;
    logic              fl;
    logic              arb_en;
    logic              arb_found;

    // A flush wins over writes in IDLE: explicit request, a coalesced pending
    // request, or a full word's worth of accepted nibbles.
    assign fl = (state == IDLE) &&
                (flush_req_i || pend || (nib_cnt == CNT_W'(WORD_NIBBLES)));

    // Writes are offered only in IDLE, with no flush due and room in the FIFO.
    assign arb_en = (state == IDLE) && !fl && !fifo_full_i && !reset;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (arb_en),
        .valid  (req_valid_i),
        .grant  (req_ready_o),
        .found  (arb_found)
    );

    assign fifo_wr_valid_o = arb_found;

    // Route the grantee's nibble onto the FIFO write port.
    always_comb begin
        fifo_wr_data_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready_o[i]) begin
                fifo_wr_data_o = req_data_i[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    // Next-state logic: phase sequencing, flush hold countdown, nibble count
    // and the single-deep pending flush flag.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        nib_nxt   = nib_cnt;
        pend_nxt  = pend;
        case (state)
            IDLE: begin
                if (fl) begin
                    state_nxt = FLUSH;
                    hold_nxt  = HOLD_W'(FLUSH_HOLD - 1);
                    nib_nxt   = '0;
                    pend_nxt  = 1'b0;
                end else if (arb_found) begin
                    nib_nxt = nib_cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (flush_req_i) begin
                    pend_nxt = 1'b1;
                end
                if (hold_cnt == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            CAPTURE: begin
                if (flush_req_i) begin
                    pend_nxt = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            nib_cnt  <= '0;
            pend     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            nib_cnt  <= nib_nxt;
            pend     <= pend_nxt;
        end
    end

    // Registered outputs: flush/busy follow the phase being entered, the word is
    // latched during CAPTURE and announced in the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: word_o is a single output register, not storage, so it is reset like any other flop.
        if (reset) begin
            fifo_flush_o <= 1'b0;
            busy_o       <= 1'b0;
            word_valid_o <= 1'b0;
            word_o       <= '0;
        end else begin
            fifo_flush_o <= (state_nxt == FLUSH);
            busy_o       <= (state_nxt != IDLE);
            word_valid_o <= (state == CAPTURE);
            if (state == CAPTURE) begin
                word_o <= fifo_rd_data_i;
            end
        end
    end

endmodule
